// File: rtl/mips_pkg.sv
// Shared MIPS opcode map, instruction-kind encoding and loader state
// encoding. The main decoder uses the same opcode constants, which keeps
// the loader's encoder and the decoder in step.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BLE   = 6'b011111;
  localparam logic [5:0] OP_STOP  = 6'b111111;

  // Word that halts the simulated core.
  localparam logic [31:0] STOP_WORD = {OP_STOP, 26'd0};

  typedef enum logic [3:0] {
    K_RTYPE = 4'd0,
    K_LW    = 4'd1,
    K_SW    = 4'd2,
    K_BEQ   = 4'd3,
    K_ADDI  = 4'd4,
    K_J     = 4'd5,
    K_LI    = 4'd6,
    K_SB    = 4'd7,
    K_BLE   = 4'd8
  } instr_kind_t;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_LOAD = 2'd1,
    LS_DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-request channel: abstract instruction fields with a
// valid/ready handshake. The producer (bench or boot flow) is the master,
// the loader is the slave.
interface imem_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    output in_ready
  );

endinterface

// File: rtl/imem_loader_pack.sv
// Combinational instruction encoder: maps an abstract instruction kind and
// its fields onto a 32-bit MIPS word. Kinds outside the opcode map report
// legal=0 and produce a zero word.
module instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word
);

  // Select the field layout and opcode for the requested kind.
  always_comb begin
    legal = 1'b1;
    word  = 32'd0;
    case (kind)
      K_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
      K_LW:    word = {OP_LW,   rs, rt, imm};
      K_SW:    word = {OP_SW,   rs, rt, imm};
      K_BEQ:   word = {OP_BEQ,  rs, rt, imm};
      K_ADDI:  word = {OP_ADDI, rs, rt, imm};
      K_J:     word = {OP_J,    target};
      K_LI:    word = {OP_LI,   5'd0, rt, imm};
      K_SB:    word = {OP_SB,   rs, rt, imm};
      K_BLE:   word = {OP_BLE,  rs, rt, imm};
      default: begin
        legal = 1'b0;
        word  = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: accepts instruction requests, encodes them, and writes
// them to consecutive instruction-memory words, finishing with a STOP word.
// The last memory slot is always held back for STOP.
module imem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          finish,
  imem_loader_if.slave  req,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic [AW:0]   count,
  output logic          done,
  output logic          err_illegal,
  output logic          err_full
);

  localparam logic [1:0]  S_IDLE    = LS_IDLE;
  localparam logic [1:0]  S_LOAD    = LS_LOAD;
  localparam logic [1:0]  S_DONE    = LS_DONE;
  localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE       = (AW+1)'(1);

  logic [1:0]    state_r;
  logic [AW:0]   count_r;
  logic          stop_pending_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wd_r;
  logic          done_r;
  logic          err_illegal_r;
  logic          err_full_r;

  logic          legal_s;
  logic [31:0]   word_s;
  logic          load_s;
  logic          ready_s;
  logic          xfer_s;
  logic          do_data_s;
  logic          do_stop_s;
  logic          set_pend_s;
  logic          full_hit_s;

  instr_pack u_pack (
    .kind   (req.in_kind),
    .rs     (req.in_rs),
    .rt     (req.in_rt),
    .rd     (req.in_rd),
    .funct  (req.in_funct),
    .imm    (req.in_imm),
    .target (req.in_target),
    .legal  (legal_s),
    .word   (word_s)
  );

  // Handshake and write decisions, derived from registered state so that
  // in_ready never depends on in_valid.
  always_comb begin
    load_s     = 1'b0;
    ready_s    = 1'b0;
    xfer_s     = 1'b0;
    do_data_s  = 1'b0;
    do_stop_s  = 1'b0;
    set_pend_s = 1'b0;
    full_hit_s = 1'b0;
    case (state_r)
      S_LOAD: begin
        load_s     = 1'b1;
        ready_s    = (count_r < LAST_SLOT) && !stop_pending_r;
        xfer_s     = req.in_valid && ready_s;
        do_data_s  = xfer_s && legal_s;
        // A pending STOP goes out now; otherwise finish writes STOP unless
        // a data word claims this cycle, in which case STOP is deferred.
        do_stop_s  = stop_pending_r || (finish && !do_data_s);
        set_pend_s = finish && do_data_s;
        full_hit_s = req.in_valid && (count_r == LAST_SLOT);
      end
      default: begin
        load_s  = 1'b0;
        ready_s = 1'b0;
      end
    endcase
  end

  assign req.in_ready = ready_s;

  // FSM, address counter, write port registers and sticky error flags.
  // start outranks any same-cycle transfer or finish.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= S_IDLE;
      count_r        <= '0;
      stop_pending_r <= 1'b0;
      we_r           <= 1'b0;
      addr_r         <= '0;
      wd_r           <= 32'd0;
      done_r         <= 1'b0;
      err_illegal_r  <= 1'b0;
      err_full_r     <= 1'b0;
    end else if (start) begin
      state_r        <= S_LOAD;
      count_r        <= '0;
      stop_pending_r <= 1'b0;
      we_r           <= 1'b0;
      done_r         <= 1'b0;
      err_illegal_r  <= 1'b0;
      err_full_r     <= 1'b0;
    end else begin
      we_r <= 1'b0;
      if (load_s) begin
        if (do_data_s) begin
          we_r    <= 1'b1;
          addr_r  <= count_r[AW-1:0];
          wd_r    <= word_s;
          count_r <= count_r + ONE;
        end else if (do_stop_s) begin
          we_r           <= 1'b1;
          addr_r         <= count_r[AW-1:0];
          wd_r           <= STOP_WORD;
          count_r        <= count_r + ONE;
          stop_pending_r <= 1'b0;
          done_r         <= 1'b1;
          state_r        <= S_DONE;
        end
        if (set_pend_s) begin
          stop_pending_r <= 1'b1;
        end
        if (xfer_s && !legal_s) begin
          err_illegal_r <= 1'b1;
        end
        if (full_hit_s) begin
          err_full_r <= 1'b1;
        end
      end
    end
  end

  assign imem_we     = we_r;
  assign imem_addr   = addr_r;
  assign imem_wd     = wd_r;
  assign count       = count_r;
  assign done        = done_r;
  assign err_illegal = err_illegal_r;
  assign err_full    = err_full_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory: encodings,
// back-to-back throughput, illegal/full errors, STOP handling, start
// priority and mid-sequence reset.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        finish;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wd;
  logic [2:0]  count;
  logic        done;
  logic        err_illegal;
  logic        err_full;

  int checks = 0;
  int errors = 0;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .finish      (finish),
    .req         (bus),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wd     (imem_wd),
    .count       (count),
    .done        (done),
    .err_illegal (err_illegal),
    .err_full    (err_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                     input logic [25:0] target);
    bus.in_valid  = 1'b1;
    bus.in_kind   = kind;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_funct  = funct;
    bus.in_imm    = imm;
    bus.in_target = target;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    finish        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_kind   = 4'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_funct  = 6'd0;
    bus.in_imm    = 16'd0;
    bus.in_target = 26'd0;

    // Reset state.
    tick();
    tick();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wd", imem_wd, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {29'd0, done, err_illegal, err_full}, 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_ready", 32'(bus.in_ready), 32'd0);

    // ADDI rs=0 rt=8 imm=5.
    pulse_start();
    chk("load_ready", 32'(bus.in_ready), 32'd1);
    req(4'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 26'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("addi_we", 32'(imem_we), 32'd1);
    chk("addi_addr", 32'(imem_addr), 32'd0);
    chk("addi_wd", imem_wd, 32'h20080005);
    chk("addi_count", 32'(count), 32'd1);
    tick();
    chk("addi_we_drop", 32'(imem_we), 32'd0);

    // Back-to-back R-type add then J.
    pulse_start();
    req(4'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0);
    tick();
    chk("rtype_we", 32'(imem_we), 32'd1);
    chk("rtype_addr", 32'(imem_addr), 32'd0);
    chk("rtype_wd", imem_wd, 32'h01095020);
    req(4'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010);
    tick();
    bus.in_valid = 1'b0;
    chk("j_we", 32'(imem_we), 32'd1);
    chk("j_addr", 32'(imem_addr), 32'd1);
    chk("j_wd", imem_wd, 32'h08000010);
    chk("j_count", 32'(count), 32'd2);

    // Illegal kind: consumed, no write, sticky error.
    req(4'd12, 5'd1, 5'd1, 5'd1, 6'd0, 16'd0, 26'd0);
    chk("ill_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("ill_we", 32'(imem_we), 32'd0);
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_count", 32'(count), 32'd2);
    tick();
    chk("ill_sticky", 32'(err_illegal), 32'd1);

    // Fill to the STOP slot, overflow request, then finish.
    pulse_start();
    chk("start_clr_err", 32'(err_illegal), 32'd0);
    chk("start_clr_count", 32'(count), 32'd0);
    req(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0000, 26'd0);
    tick();
    chk("lw0_wd", imem_wd, 32'h8C220000);
    chk("lw0_addr", 32'(imem_addr), 32'd0);
    bus.in_imm = 16'h0004;
    tick();
    chk("lw1_wd", imem_wd, 32'h8C220004);
    chk("lw1_addr", 32'(imem_addr), 32'd1);
    bus.in_imm = 16'h0008;
    tick();
    chk("lw2_wd", imem_wd, 32'h8C220008);
    chk("lw2_addr", 32'(imem_addr), 32'd2);
    chk("lw2_count", 32'(count), 32'd3);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("full_we", 32'(imem_we), 32'd0);
    chk("full_err", 32'(err_full), 32'd1);
    chk("full_count", 32'(count), 32'd3);
    bus.in_valid = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("stop_we", 32'(imem_we), 32'd1);
    chk("stop_addr", 32'(imem_addr), 32'd3);
    chk("stop_wd", imem_wd, 32'hFC000000);
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_count", 32'(count), 32'd4);
    chk("done_ready", 32'(bus.in_ready), 32'd0);
    req(4'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    bus.in_valid = 1'b0;
    chk("done_ignore_we", 32'(imem_we), 32'd0);
    chk("done_ignore_count", 32'(count), 32'd4);
    chk("done_hold", 32'(done), 32'd1);

    // LI with finish in the same cycle: data first, STOP next.
    pulse_start();
    chk("start_clr_done", 32'(done), 32'd0);
    req(4'd6, 5'd0, 5'd2, 5'd0, 6'd0, 16'h1234, 26'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    bus.in_valid = 1'b0;
    chk("li_we", 32'(imem_we), 32'd1);
    chk("li_addr", 32'(imem_addr), 32'd0);
    chk("li_wd", imem_wd, 32'h44021234);
    chk("li_done", 32'(done), 32'd0);
    chk("pend_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("pstop_we", 32'(imem_we), 32'd1);
    chk("pstop_addr", 32'(imem_addr), 32'd1);
    chk("pstop_wd", imem_wd, 32'hFC000000);
    chk("pstop_done", 32'(done), 32'd1);
    chk("pstop_count", 32'(count), 32'd2);

    // start the cycle after a transfer: the in-flight write still shows.
    pulse_start();
    req(4'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 26'd0);
    tick();
    bus.in_valid = 1'b0;
    start = 1'b1;
    chk("inflight_we", 32'(imem_we), 32'd1);
    chk("inflight_wd", imem_wd, 32'h20080005);
    tick();
    start = 1'b0;
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_we", 32'(imem_we), 32'd0);
    req(4'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0007, 26'd0);
    tick();
    chk("restart_addr", 32'(imem_addr), 32'd0);
    chk("restart_wd", imem_wd, 32'h20080007);
    chk("restart_cnt1", 32'(count), 32'd1);

    // start in the same cycle as a transfer suppresses the write.
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("startxfer_we", 32'(imem_we), 32'd0);
    chk("startxfer_count", 32'(count), 32'd0);

    // Reset mid-LOAD with a request in flight.
    req(4'd1, 5'd3, 5'd4, 5'd0, 6'd0, 16'h00FF, 26'd0);
    reset = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("mrst_we", 32'(imem_we), 32'd0);
    chk("mrst_addr", 32'(imem_addr), 32'd0);
    chk("mrst_wd", imem_wd, 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_flags", {29'd0, done, err_illegal, err_full}, 32'd0);
    chk("mrst_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bus.in_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
